// File: rtl/game_state_scanner_pkg.sv
// game_pkg: shared types and constants for the game-state scanner.
// Holds the coordinate width, the restart keycode, the hit/scan enums and a
// helper that widens an unsigned coordinate into the signed compare domain.
package game_pkg;

    localparam int         COORD_W     = 10;
    localparam int         CALC_W      = 12;
    localparam logic [7:0] KEY_RESTART = 8'h15;

    typedef enum logic [1:0] {
        HIT_NONE  = 2'd0,
        HIT_SPIKE = 2'd1,
        HIT_APPLE = 2'd2
    } hit_type_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SCAN_SPIKE = 2'd1,
        SCAN_APPLE = 2'd2,
        PUBLISH    = 2'd3
    } scan_state_t;

    // Zero-extend a screen coordinate so offsets and differences never wrap.
    function automatic logic signed [CALC_W-1:0] to_calc(input logic [COORD_W-1:0] v);
        return $signed({2'b00, v});
    endfunction

endpackage

// File: rtl/game_state_scanner_spike_tri_hit.sv
// spike_tri_hit: combinational test of the player against one triangular spike.
// Three probe columns (left/centre/right of the player) are checked against
// the triangle profile; up-spikes use the player's bottom row, down-spikes the
// top row.
// Ports:
//   i_man_x, i_man_y     player top-left (snapshot)
//   i_spike_x, i_spike_y spike top-left
//   i_down               0 = spike points up, 1 = points down
//   o_hit                player overlaps the spike
module spike_tri_hit
    import game_pkg::*;
#(
    parameter int SPIKE_W = 20,
    parameter int HB_L    = 4,
    parameter int HB_C    = 10,
    parameter int HB_R    = 15,
    parameter int HB_B    = 19,
    parameter int HB_T    = 0
) (
    input  logic [COORD_W-1:0] i_man_x,
    input  logic [COORD_W-1:0] i_man_y,
    input  logic [COORD_W-1:0] i_spike_x,
    input  logic [COORD_W-1:0] i_spike_y,
    input  logic               i_down,
    output logic               o_hit
);

    localparam logic signed [CALC_W-1:0] C_W    = CALC_W'(SPIKE_W);
    localparam logic signed [CALC_W-1:0] C_HB_B = CALC_W'(HB_B);
    localparam logic signed [CALC_W-1:0] C_HB_T = CALC_W'(HB_T);

    logic signed [CALC_W-1:0] w_man_x;
    logic signed [CALC_W-1:0] w_man_y;
    logic signed [CALC_W-1:0] w_spike_x;
    logic signed [CALC_W-1:0] w_spike_y;
    logic signed [CALC_W-1:0] w_row_up;
    logic signed [CALC_W-1:0] w_row_dn;
    logic [2:0]               w_probe_hit;

    assign w_man_x   = to_calc(i_man_x);
    assign w_man_y   = to_calc(i_man_y);
    assign w_spike_x = to_calc(i_spike_x);
    assign w_spike_y = to_calc(i_spike_y);
    assign w_row_up  = w_man_y + C_HB_B;
    assign w_row_dn  = w_man_y + C_HB_T;

    for (genvar g = 0; g < 3; g++) begin : g_probe
        localparam int                       OFF   = (g == 0) ? HB_L : ((g == 1) ? HB_C : HB_R);
        localparam logic signed [CALC_W-1:0] C_OFF = CALC_W'(OFF);

        logic signed [CALC_W-1:0] w_dx;
        logic signed [CALC_W-1:0] w_mirror;
        logic signed [CALC_W-1:0] w_d2;
        logic                     w_in_col;
        logic                     w_up_hit;
        logic                     w_dn_hit;

        assign w_dx     = w_man_x + C_OFF - w_spike_x;
        assign w_in_col = (w_dx >= 12'sd0) && (w_dx < C_W);
        // Distance to the nearer triangle edge, doubled: the triangle rises
        // two rows per column from each side.
        assign w_mirror = C_W - 12'sd1 - w_dx;
        assign w_d2     = (w_dx < w_mirror) ? (w_dx + w_dx) : (w_mirror + w_mirror);
        assign w_up_hit = (w_row_up >= w_spike_y + C_W - 12'sd2 - w_d2) &&
                          (w_row_up <= w_spike_y + C_W - 12'sd1);
        assign w_dn_hit = (w_row_dn >= w_spike_y) && (w_row_dn <= w_spike_y + w_d2);
        assign w_probe_hit[g] = w_in_col && (i_down ? w_dn_hit : w_up_hit);
    end

    assign o_hit = |w_probe_hit;

endmodule

// File: rtl/game_state_scanner.sv
// game_state_scanner: per-frame sequential collision / goal / restart checker.
// On frame_start the player position is snapshotted and spikes, then apples,
// are tested one per clock through a shared hit test; the first hit ends the
// scan. Results are registered and announced with a one-cycle result_valid.
// Ports:
//   Clk, Reset              clock, synchronous active-high reset
//   frame_start             scan trigger
//   ManX, ManY              player top-left
//   keycode                 two USB keycodes (restart detection)
//   Draw_direction, spike_en, SpikeX, SpikeY   spike table
//   apple_en, AppleX, AppleY                   apple table
//   result_valid, collide, hit_type, hit_index, level_complete   scan results
//   restart_req             one pulse per restart key press
//   overrun                 frame_start arrived while not idle
//   busy                    scan (or publish) in progress
module game_state_scanner
    import game_pkg::*;
#(
    parameter  int NUM_SPIKES  = 24,
    parameter  int NUM_APPLES  = 4,
    parameter  int SPIKE_W     = 20,
    parameter  int HB_L        = 4,
    parameter  int HB_C        = 10,
    parameter  int HB_R        = 15,
    parameter  int HB_B        = 19,
    parameter  int HB_T        = 0,
    parameter  int APPLE_DX    = 10,
    parameter  int APPLE_DY_LO = 8,
    parameter  int APPLE_DY_HI = 14,
    parameter  int GOAL_X_MAX  = 10,
    parameter  int GOAL_Y      = 215,
    localparam int MAX_OBJ     = (NUM_SPIKES > NUM_APPLES) ? NUM_SPIKES : NUM_APPLES,
    localparam int IDX_W       = (MAX_OBJ > 1) ? $clog2(MAX_OBJ) : 1
) (
    input  logic                                  Clk,
    input  logic                                  Reset,
    input  logic                                  frame_start,
    input  logic [COORD_W-1:0]                    ManX,
    input  logic [COORD_W-1:0]                    ManY,
    input  logic [15:0]                           keycode,
    input  logic [NUM_SPIKES-1:0]                 Draw_direction,
    input  logic [NUM_SPIKES-1:0]                 spike_en,
    input  logic [NUM_SPIKES-1:0][COORD_W-1:0]    SpikeX,
    input  logic [NUM_SPIKES-1:0][COORD_W-1:0]    SpikeY,
    input  logic [NUM_APPLES-1:0]                 apple_en,
    input  logic [NUM_APPLES-1:0][COORD_W-1:0]    AppleX,
    input  logic [NUM_APPLES-1:0][COORD_W-1:0]    AppleY,
    output logic                                  result_valid,
    output logic                                  collide,
    output hit_type_t                             hit_type,
    output logic [IDX_W-1:0]                      hit_index,
    output logic                                  level_complete,
    output logic                                  restart_req,
    output logic                                  overrun,
    output logic                                  busy
);

    localparam int SIDX_W = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;
    localparam int AIDX_W = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;

    localparam logic signed [CALC_W-1:0] C_APPLE_DX = CALC_W'(APPLE_DX);
    localparam logic signed [CALC_W-1:0] C_DY_LO    = CALC_W'(APPLE_DY_LO);
    localparam logic signed [CALC_W-1:0] C_DY_HI    = CALC_W'(APPLE_DY_HI);

    scan_state_t          r_state;
    logic [IDX_W-1:0]     r_idx;
    logic [COORD_W-1:0]   r_man_x;
    logic [COORD_W-1:0]   r_man_y;
    logic                 r_busy;
    logic                 r_result_valid;
    logic                 r_collide;
    hit_type_t            r_hit_type;
    logic [IDX_W-1:0]     r_hit_index;
    logic                 r_level_complete;
    logic                 r_overrun;
    logic                 r_key_prev;
    logic                 r_restart_req;

    logic [SIDX_W-1:0]        w_sidx;
    logic [AIDX_W-1:0]        w_aidx;
    logic                     w_tri_hit;
    logic                     w_spike_hit;
    logic                     w_apple_hit;
    logic                     w_goal;
    logic                     w_key_now;
    logic signed [CALC_W-1:0] w_adx;
    logic signed [CALC_W-1:0] w_adx_abs;
    logic signed [CALC_W-1:0] w_apple_y;
    logic signed [CALC_W-1:0] w_snap_y;

    assign w_sidx = r_idx[SIDX_W-1:0];
    assign w_aidx = r_idx[AIDX_W-1:0];

    spike_tri_hit #(
        .SPIKE_W (SPIKE_W),
        .HB_L    (HB_L),
        .HB_C    (HB_C),
        .HB_R    (HB_R),
        .HB_B    (HB_B),
        .HB_T    (HB_T)
    ) u_spike_tri_hit (
        .i_man_x   (r_man_x),
        .i_man_y   (r_man_y),
        .i_spike_x (SpikeX[w_sidx]),
        .i_spike_y (SpikeY[w_sidx]),
        .i_down    (Draw_direction[w_sidx]),
        .o_hit     (w_tri_hit)
    );

    assign w_spike_hit = spike_en[w_sidx] && w_tri_hit;

    // Apple window in the signed domain so AppleX < APPLE_DX cannot underflow.
    assign w_adx       = to_calc(r_man_x) - to_calc(AppleX[w_aidx]);
    assign w_adx_abs   = (w_adx < 12'sd0) ? -w_adx : w_adx;
    assign w_apple_y   = to_calc(AppleY[w_aidx]);
    assign w_snap_y    = to_calc(r_man_y);
    assign w_apple_hit = apple_en[w_aidx] && (w_adx_abs <= C_APPLE_DX) &&
                         (w_snap_y > w_apple_y - C_DY_LO) && (w_snap_y < w_apple_y + C_DY_HI);

    assign w_goal    = (r_man_x <= COORD_W'(GOAL_X_MAX)) && (r_man_y == COORD_W'(GOAL_Y));
    assign w_key_now = (keycode[7:0] == KEY_RESTART) || (keycode[15:8] == KEY_RESTART);

    // Scan FSM: results are loaded on the cycle the scan ends, so PUBLISH is
    // the cycle in which result_valid is visible.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state          <= IDLE;
            r_idx            <= '0;
            r_man_x          <= '0;
            r_man_y          <= '0;
            r_busy           <= 1'b0;
            r_result_valid   <= 1'b0;
            r_collide        <= 1'b0;
            r_hit_type       <= HIT_NONE;
            r_hit_index      <= '0;
            r_level_complete <= 1'b0;
            r_overrun        <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_overrun      <= frame_start && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_man_x <= ManX;
                        r_man_y <= ManY;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SCAN_SPIKE;
                    end
                end
                SCAN_SPIKE: begin
                    if (w_spike_hit) begin
                        r_result_valid   <= 1'b1;
                        r_collide        <= 1'b1;
                        r_hit_type       <= HIT_SPIKE;
                        r_hit_index      <= r_idx;
                        r_level_complete <= w_goal;
                        r_state          <= PUBLISH;
                    end else if (r_idx == IDX_W'(NUM_SPIKES - 1)) begin
                        r_idx   <= '0;
                        r_state <= SCAN_APPLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                SCAN_APPLE: begin
                    if (w_apple_hit) begin
                        r_result_valid   <= 1'b1;
                        r_collide        <= 1'b1;
                        r_hit_type       <= HIT_APPLE;
                        r_hit_index      <= r_idx;
                        r_level_complete <= w_goal;
                        r_state          <= PUBLISH;
                    end else if (r_idx == IDX_W'(NUM_APPLES - 1)) begin
                        r_result_valid   <= 1'b1;
                        r_collide        <= 1'b0;
                        r_hit_type       <= HIT_NONE;
                        r_hit_index      <= '0;
                        r_level_complete <= w_goal;
                        r_state          <= PUBLISH;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                PUBLISH: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Restart key edge detector, free-running alongside the scan.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_key_prev    <= 1'b0;
            r_restart_req <= 1'b0;
        end else begin
            r_key_prev    <= w_key_now;
            r_restart_req <= w_key_now && !r_key_prev;
        end
    end

    assign result_valid   = r_result_valid;
    assign collide        = r_collide;
    assign hit_type       = r_hit_type;
    assign hit_index      = r_hit_index;
    assign level_complete = r_level_complete;
    assign restart_req    = r_restart_req;
    assign overrun        = r_overrun;
    assign busy           = r_busy;

endmodule

// File: tb/tb_game_state_scanner.sv
module tb_game_state_scanner;

    localparam int NS = 24, NA = 4, SW = 20;
    localparam int HBL = 4, HBC = 10, HBR = 15, HBB = 19, HBT = 0;
    localparam int ADX = 10, ALO = 8, AHI = 14, GXM = 10, GY = 215;

    logic                 Clk = 1'b0;
    logic                 Reset = 1'b1;
    logic                 frame_start = 1'b0;
    logic [9:0]           ManX = '0, ManY = '0;
    logic [15:0]          keycode = '0;
    logic [NS-1:0]        Draw_direction = '0, spike_en = '0;
    logic [NS-1:0][9:0]   SpikeX = '0, SpikeY = '0;
    logic [NA-1:0]        apple_en = '0;
    logic [NA-1:0][9:0]   AppleX = '0, AppleY = '0;
    logic                 result_valid, collide, level_complete, restart_req, overrun, busy;
    logic [1:0]           hit_type;
    logic [4:0]           hit_index;

    int n_checks = 0;
    int n_errors = 0;

    game_state_scanner dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .ManX(ManX), .ManY(ManY),
        .keycode(keycode), .Draw_direction(Draw_direction), .spike_en(spike_en),
        .SpikeX(SpikeX), .SpikeY(SpikeY), .apple_en(apple_en), .AppleX(AppleX), .AppleY(AppleY),
        .result_valid(result_valid), .collide(collide), .hit_type(hit_type), .hit_index(hit_index),
        .level_complete(level_complete), .restart_req(restart_req), .overrun(overrun), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    function automatic bit spike_hits(int mx, int my, int sx, int sy, bit down);
        int offs[3];
        offs[0] = HBL; offs[1] = HBC; offs[2] = HBR;
        for (int p = 0; p < 3; p++) begin
            int dx, d, row;
            dx = mx + offs[p] - sx;
            if (dx >= 0 && dx < SW) begin
                d = (dx < SW - 1 - dx) ? dx : SW - 1 - dx;
                if (!down) begin
                    row = my + HBB;
                    if (row >= sy + SW - 2 - 2 * d && row <= sy + SW - 1) return 1'b1;
                end else begin
                    row = my + HBT;
                    if (row >= sy && row <= sy + 2 * d) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    function automatic bit apple_hits(int mx, int my, int ax, int ay);
        int adx;
        adx = (mx > ax) ? mx - ax : ax - mx;
        return (adx <= ADX) && (my > ay - ALO) && (my < ay + AHI);
    endfunction

    bit m_ready = 1'b0, m_active = 1'b0, m_key_prev = 1'b0;
    int m_cnt, m_lat, m_rc, m_rt, m_ri, m_rl;
    int e_valid, e_collide, e_type, e_idx, e_lc, e_restart, e_overrun, e_busy;

    // Work out the whole scan outcome and its latency at the moment it starts.
    task automatic model_start();
        int k;
        k = -1;
        for (int i = 0; i < NS && k < 0; i++)
            if (spike_en[i] && spike_hits(ManX, ManY, SpikeX[i], SpikeY[i], Draw_direction[i])) begin
                k = i; m_rt = 1; m_ri = i;
            end
        for (int j = 0; j < NA && k < 0; j++)
            if (apple_en[j] && apple_hits(ManX, ManY, AppleX[j], AppleY[j])) begin
                k = NS + j; m_rt = 2; m_ri = j;
            end
        if (k < 0) begin
            m_rc = 0; m_rt = 0; m_ri = 0; m_lat = NS + NA + 1;
        end else begin
            m_rc = 1; m_lat = k + 2;
        end
        m_rl = (ManX <= GXM) && (ManY == GY);
        m_active = 1'b1; m_cnt = 0; e_busy = 1;
    endtask

    task automatic model_advance();
        bit key_now;
        if (Reset === 1'b1) begin
            m_ready = 1'b1; m_active = 1'b0; m_key_prev = 1'b0;
            e_valid = 0; e_collide = 0; e_type = 0; e_idx = 0; e_lc = 0;
            e_restart = 0; e_overrun = 0; e_busy = 0;
        end else if (m_ready) begin
            key_now = (keycode[7:0] == 8'h15) || (keycode[15:8] == 8'h15);
            e_restart = key_now && !m_key_prev;
            m_key_prev = key_now;
            e_valid = 0; e_overrun = 0;
            if (!m_active) begin
                if (frame_start) model_start();
            end else begin
                if (frame_start) e_overrun = 1;
                m_cnt++;
                if (m_cnt == m_lat - 1) begin
                    e_valid = 1; e_collide = m_rc; e_type = m_rt; e_idx = m_ri; e_lc = m_rl;
                end else if (m_cnt == m_lat) begin
                    m_active = 1'b0; e_busy = 0;
                end
            end
        end
    endtask

    // Compare process: inputs change just after posedge, so at negedge the
    // outputs reflect the last edge and the inputs are what the next edge sees.
    initial begin
        forever begin
            @(negedge Clk);
            if (m_ready) begin
                check("result_valid", result_valid, e_valid);
                check("collide", collide, e_collide);
                check("hit_type", hit_type, e_type);
                check("hit_index", hit_index, e_idx);
                check("level_complete", level_complete, e_lc);
                check("restart_req", restart_req, e_restart);
                check("overrun", overrun, e_overrun);
                check("busy", busy, e_busy);
            end
            model_advance();
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_objects();
        spike_en = '0; apple_en = '0; Draw_direction = '0;
        SpikeX = '0; SpikeY = '0; AppleX = '0; AppleY = '0;
    endtask

    function automatic logic [9:0] clamp(int v);
        if (v < 0) return 10'd0;
        if (v > 1023) return 10'd1023;
        return 10'(v);
    endfunction

    // Start a scan in cycle 0 and check literal latency/results.
    task automatic scan_lit(input string nm, input int mx, input int my, input int exp_cyc,
                            input int ec, input int et, input int ei, input int el);
        int cyc;
        ManX = 10'(mx); ManY = 10'(my); frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        cyc = 1;
        while (result_valid !== 1'b1 && cyc < 64) begin
            step();
            cyc++;
        end
        check({nm, "_cycle"}, cyc, exp_cyc);
        check({nm, "_collide"}, collide, ec);
        check({nm, "_type"}, hit_type, et);
        check({nm, "_index"}, hit_index, ei);
        check({nm, "_level"}, level_complete, el);
        step();
        step();
    endtask

    initial begin
        int pulses, longp, w, t, bx, by;
        bit prev;

        repeat (3) step();
        Reset = 1'b0;
        step();
        check("rst_valid", result_valid, 0);
        check("rst_collide", collide, 0);
        check("rst_type", hit_type, 0);
        check("rst_busy", busy, 0);

        // Up spike 0
        clear_objects();
        spike_en[0] = 1'b1; SpikeX[0] = 10'd100; SpikeY[0] = 10'd200;
        scan_lit("up_hit", 86, 198, 2, 1, 1, 0, 0);
        scan_lit("up_miss", 86, 196, 29, 0, 0, 0, 0);

        // Down spike 5
        clear_objects();
        spike_en[5] = 1'b1; Draw_direction[5] = 1'b1; SpikeX[5] = 10'd200; SpikeY[5] = 10'd100;
        scan_lit("down_miss", 190, 112, 29, 0, 0, 0, 0);
        scan_lit("down_hit", 195, 104, 7, 1, 1, 5, 0);

        // Apples
        clear_objects();
        apple_en[2] = 1'b1; AppleX[2] = 10'd300; AppleY[2] = 10'd100;
        scan_lit("apple2", 295, 110, 28, 1, 2, 2, 0);
        clear_objects();
        apple_en[0] = 1'b1; AppleX[0] = 10'd5; AppleY[0] = 10'd50;
        scan_lit("apple_edge", 0, 50, 26, 1, 2, 0, 0);

        // Goal
        clear_objects();
        scan_lit("goal", 10, 215, 29, 0, 0, 0, 1);
        scan_lit("goal_x", 11, 215, 29, 0, 0, 0, 0);
        scan_lit("goal_y", 10, 214, 29, 0, 0, 0, 0);

        // Restart key: two presses, one held for five cycles
        keycode = 16'h0000;
        step(); step();
        pulses = 0; longp = 0; prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            keycode = (i < 5) ? 16'h1500 : ((i < 8) ? 16'h0000 : 16'h0015);
            step();
            if (restart_req === 1'b1) begin
                pulses++;
                if (prev) longp++;
            end
            prev = (restart_req === 1'b1);
        end
        keycode = 16'h0000;
        check("restart_pulses", pulses, 2);
        check("restart_long", longp, 0);

        // Overrun then reset mid-scan
        clear_objects();
        spike_en[0] = 1'b1; SpikeX[0] = 10'd24; SpikeY[0] = 10'd215;
        scan_lit("goal_spike", 10, 215, 2, 1, 1, 0, 1);
        clear_objects();
        ManX = 10'd50; ManY = 10'd50; frame_start = 1'b1;
        step(); frame_start = 1'b0;       // cycle 1
        step(); step();                   // cycle 3
        frame_start = 1'b1;
        step(); frame_start = 1'b0;       // cycle 4
        check("overrun_pulse", overrun, 1);
        check("overrun_busy", busy, 1);
        step();                           // cycle 5
        Reset = 1'b1;
        step(); Reset = 1'b0;             // cycle 6
        check("abort_valid", result_valid, 0);
        check("abort_collide", collide, 0);
        check("abort_level", level_complete, 0);
        check("abort_busy", busy, 0);
        step();                           // cycle 7
        check("abort_quiet", result_valid, 0);
        step();                           // cycle 8
        scan_lit("fresh", 50, 50, 29, 0, 0, 0, 0);

        // Randomised scans aimed near a random object
        for (int it = 0; it < 80; it++) begin
            frame_start = 1'b0;
            w = 0;
            while (m_active && w < 200) begin
                step();
                w++;
            end
            if (w >= 200) check("idle_timeout", busy, 0);
            for (int i = 0; i < NS; i++) begin
                spike_en[i] = ($urandom_range(0, 2) == 0);
                Draw_direction[i] = 1'($urandom_range(0, 1));
                SpikeX[i] = 10'($urandom_range(0, 600));
                SpikeY[i] = 10'($urandom_range(0, 460));
            end
            for (int j = 0; j < NA; j++) begin
                apple_en[j] = 1'($urandom_range(0, 1));
                AppleX[j] = 10'($urandom_range(0, 600));
                AppleY[j] = 10'($urandom_range(0, 460));
            end
            t = $urandom_range(0, NS + NA);
            if (t < NS) begin
                if ($urandom_range(0, 3) != 0) spike_en[t] = 1'b1;
                bx = int'(SpikeX[t]) - 16 + $urandom_range(0, 22);
                by = Draw_direction[t] ? int'(SpikeY[t]) - 2 + $urandom_range(0, 20)
                                       : int'(SpikeY[t]) - 12 + $urandom_range(0, 14);
            end else if (t < NS + NA) begin
                if ($urandom_range(0, 3) != 0) apple_en[t - NS] = 1'b1;
                bx = int'(AppleX[t - NS]) - 12 + $urandom_range(0, 24);
                by = int'(AppleY[t - NS]) - 10 + $urandom_range(0, 26);
            end else begin
                bx = $urandom_range(8, 12);
                by = $urandom_range(214, 216);
            end
            for (int c = 0; c < 40; c++) begin
                ManX = clamp(bx + $urandom_range(0, 2) - 1);
                ManY = clamp(by + $urandom_range(0, 2) - 1);
                frame_start = ($urandom_range(0, 5) == 0);
                Reset = ($urandom_range(0, 399) == 0);
                case ($urandom_range(0, 5))
                    0: keycode = 16'h0015;
                    1: keycode = 16'h1500;
                    2: keycode = 16'($urandom_range(0, 65535));
                    3: keycode = keycode;
                    default: keycode = 16'h0000;
                endcase
                step();
            end
            Reset = 1'b0;
        end
        frame_start = 1'b0;
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
